// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential divider.
// master drives operands and start; slave returns status and registered results.
interface seq_divider_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle MSB first; done N cycles after accept (1 for /0).
// No backpressure: start is only honoured in IDLE (including the done cycle) and ignored while busy.
module seq_divider #(
    parameter int N = 4
) (
    input  logic          clk,
    input  logic          rst,
    seq_divider_if.slave  div_if
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t         state_q, state_d;
    logic           busy;

    logic [N-1:0]   dvd_q;
    logic [N-1:0]   dvs_q;
    logic [N:0]     rem_q;
    logic [CW-1:0]  cnt_q;
    logic           done_q;
    logic           dbz_q;
    logic [N-1:0]   quotient_q;
    logic [N-1:0]   remainder_q;

    logic           accept;
    logic           div_zero;
    logic           last;
    logic [N+1:0]   shifted;
    logic           ge;
    logic [N:0]     diff;
    logic [N:0]     rem_next;
    logic [N-1:0]   quo_next;

    assign accept   = (state_q == IDLE) && div_if.start;
    assign div_zero = (div_if.divisor == '0);
    assign last     = (cnt_q == CW'(N - 1));

    // The dividend register doubles as the quotient register: dividend bits
    // leave at the top while quotient bits enter at the bottom.
    assign shifted  = {rem_q, dvd_q[N-1]};
    assign ge       = (shifted >= {2'b00, dvs_q});
    assign diff     = shifted[N:0] - {1'b0, dvs_q};
    assign rem_next = ge ? diff : shifted[N:0];
    assign quo_next = {dvd_q[N-2:0], ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept && !div_zero) state_d = CALC;
            CALC: if (last)                state_d = IDLE;
            default:                       state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (state_q == CALC) busy = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                dvd_q <= div_if.dividend;
                dvs_q <= div_if.divisor;
                rem_q <= '0;
                cnt_q <= '0;
                if (div_zero) begin
                    done_q      <= 1'b1;
                    dbz_q       <= 1'b1;
                    quotient_q  <= '1;
                    remainder_q <= div_if.dividend;
                end
            end else if (state_q == CALC) begin
                dvd_q <= quo_next;
                rem_q <= rem_next;
                cnt_q <= cnt_q + CW'(1);
                if (last) begin
                    done_q      <= 1'b1;
                    dbz_q       <= 1'b0;
                    quotient_q  <= quo_next;
                    remainder_q <= rem_next[N-1:0];
                end
            end
        end
    end

    assign div_if.busy        = busy;
    assign div_if.done        = done_q;
    assign div_if.quotient    = quotient_q;
    assign div_if.remainder   = remainder_q;
    assign div_if.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and sweep tests for seq_divider at N=4 and N=8 against a / and % scoreboard.
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int q;
        int r;
        int dz;
        int edges;
        int c_issue;
    } exp_t;

    exp_t sb4[$];
    exp_t sb8[$];

    seq_divider_if #(.N(4)) if4();
    seq_divider_if #(.N(8)) if8();

    seq_divider #(.N(4)) dut4 (.clk(clk), .rst(rst), .div_if(if4));
    seq_divider #(.N(8)) dut8 (.clk(clk), .rst(rst), .div_if(if8));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Edge count runs from the driving negedge, so it includes the accept edge.
    task automatic issue(input int n, input int a, input int b);
        exp_t e;
        e.q       = (b == 0) ? (1 << n) - 1 : a / b;
        e.r       = (b == 0) ? a : a % b;
        e.dz      = (b == 0) ? 1 : 0;
        e.edges   = (b == 0) ? 1 : n + 1;
        e.c_issue = cyc;
        if (n == 4) begin
            if4.start    = 1'b1;
            if4.dividend = 4'(a);
            if4.divisor  = 4'(b);
            sb4.push_back(e);
        end else begin
            if8.start    = 1'b1;
            if8.dividend = 8'(a);
            if8.divisor  = 8'(b);
            sb8.push_back(e);
        end
    endtask

    task automatic wait_done(input int n, input string tag);
        exp_t       e;
        logic       got;
        logic [7:0] q, r;
        logic       dz, bz;
        got = 1'b0;
        for (int k = 0; k < 40 && got !== 1'b1; k++) begin
            @(negedge clk);
            got = (n == 4) ? if4.done : if8.done;
        end
        check({tag, "_done"}, 32'(got), 32'd1);
        if (got === 1'b1) begin
            e = '{-1, -1, -1, -1, 0};
            if (n == 4) begin
                q  = {4'b0, if4.quotient};
                r  = {4'b0, if4.remainder};
                dz = if4.div_by_zero;
                bz = if4.busy;
                if (sb4.size() > 0) e = sb4.pop_front();
            end else begin
                q  = if8.quotient;
                r  = if8.remainder;
                dz = if8.div_by_zero;
                bz = if8.busy;
                if (sb8.size() > 0) e = sb8.pop_front();
            end
            check({tag, "_lat"},  32'(cyc - e.c_issue), 32'(e.edges));
            check({tag, "_q"},    32'(q),  32'(e.q));
            check({tag, "_r"},    32'(r),  32'(e.r));
            check({tag, "_dbz"},  32'(dz), 32'(e.dz));
            check({tag, "_busy"}, 32'(bz), 32'd0);
        end
    endtask

    initial begin
        int a;
        if4.start = 1'b0; if4.dividend = '0; if4.divisor = '0;
        if8.start = 1'b0; if8.dividend = '0; if8.divisor = '0;

        repeat (3) @(negedge clk);
        check("rst4_busy", 32'(if4.busy), 0);
        check("rst4_done", 32'(if4.done), 0);
        check("rst4_q",    32'(if4.quotient), 0);
        check("rst4_r",    32'(if4.remainder), 0);
        check("rst4_dbz",  32'(if4.div_by_zero), 0);
        check("rst8_busy", 32'(if8.busy), 0);
        check("rst8_done", 32'(if8.done), 0);
        check("rst8_q",    32'(if8.quotient), 0);
        rst = 1'b0;
        @(negedge clk);

        // 13/3: busy during CALC, q=4 r=1 after four iterations.
        issue(4, 13, 3);
        @(negedge clk);
        if4.start = 1'b0;
        check("d13_3_busy", 32'(if4.busy), 1);
        wait_done(4, "d13_3");
        @(negedge clk);
        check("d13_3_pulse", 32'(if4.done), 0);

        // 7/0: result in the cycle after accept, busy never rises.
        issue(4, 7, 0);
        wait_done(4, "d7_0");
        if4.start = 1'b0;
        @(negedge clk);
        check("d7_0_pulse", 32'(if4.done), 0);
        check("d7_0_busy2", 32'(if4.busy), 0);
        check("d7_0_hold_q", 32'(if4.quotient), 15);
        check("d7_0_hold_dbz", 32'(if4.div_by_zero), 1);

        // 2/9 then 15/1 with start held through done.
        issue(4, 2, 9);
        wait_done(4, "b2b_2_9");
        issue(4, 15, 1);
        wait_done(4, "b2b_15_1");
        if4.start = 1'b0;
        @(negedge clk);
        check("b2b_pulse", 32'(if4.done), 0);

        // 12/5 with a 9/2 request pulsed mid-CALC that must be ignored.
        issue(4, 12, 5);
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        if4.start = 1'b1; if4.dividend = 4'd9; if4.divisor = 4'd2;
        @(negedge clk);
        if4.start = 1'b0;
        wait_done(4, "ign_12_5");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("ign_no_done", 32'(if4.done), 0);
        end
        check("ign_sb_empty", 32'(sb4.size()), 0);

        // 14/4 aborted by reset on the second CALC cycle.
        issue(4, 14, 4);
        @(negedge clk);
        if4.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(if4.busy), 0);
        check("abort_done", 32'(if4.done), 0);
        check("abort_q",    32'(if4.quotient), 0);
        check("abort_r",    32'(if4.remainder), 0);
        check("abort_dbz",  32'(if4.div_by_zero), 0);
        void'(sb4.pop_front());
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_no_done", 32'(if4.done), 0);
            check("abort_idle",    32'(if4.busy), 0);
        end
        issue(4, 14, 4);
        @(negedge clk);
        if4.start = 1'b0;
        wait_done(4, "retry_14_4");

        // Exhaustive N=4 sweep, back-to-back.
        @(negedge clk);
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                issue(4, x, y);
                wait_done(4, "sweep4");
            end
        end
        if4.start = 1'b0;

        // N=8: every divisor against edge and random dividends, then random pairs.
        @(negedge clk);
        for (int y = 0; y < 256; y++) begin
            for (int j = 0; j < 4; j++) begin
                a = (j == 0) ? 0 : (j == 1) ? y : (j == 2) ? 255 : int'($urandom_range(0, 255));
                issue(8, a, y);
                wait_done(8, "sweep8");
            end
        end
        for (int k = 0; k < 600; k++) begin
            issue(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            wait_done(8, "rand8");
        end
        if8.start = 1'b0;
        @(negedge clk);
        check("end8_pulse", 32'(if8.done), 0);
        check("end_sb_empty", 32'(sb4.size() + sb8.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
